alu_rr_scheduler: RTL and testbench

Shares the single 4-bit ALU among NUM_REQ requesters using a round-robin grant and a valid/ready handshake on both sides. Per operation: latches the winner's operands and opcode, drives the ALU for one cycle with enable high, and captures {cout,out}. Returns the captured result with the requester ID. Sits between the requesting blocks and the ALU instance in the parent; the ALU stays combinational and is instantiated by the parent.

---
 rtl/alu_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/alu_rr_scheduler.sv | 167 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: ALU opcodes and
// the scheduler FSM state encoding.
package alu_sched_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_RESP  = 2'b10
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant on the first set request
// at or above the pointer, wrapping around to requester 0.
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       any_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;

    // Scan requesters starting at the pointer; the one extra bit on sum_s
    // covers ptr+offset before the modulo wrap.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        sum_s       = '0;
        idx_s       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDX_W-1:0];
            if (!any_o && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                grant_idx_o    = idx_s;
                any_o          = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin accept,
// one ALU cycle, then a held response until the consumer takes it.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*2-1:0]       req_op,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       alu_enable,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [1:0]                 alu_opcode,
    input  logic [WIDTH-1:0]           alu_out,
    input  logic                       alu_cout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH:0]             rsp_data,
    output logic [CNT_W-1:0]           op_count,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_e      state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;
    logic [IDX_W-1:0]  id_q;
    logic              alu_enable_q;
    logic [WIDTH-1:0]  alu_a_q;
    logic [WIDTH-1:0]  alu_b_q;
    logic [1:0]        alu_op_q;
    logic              rsp_valid_q;
    logic [IDX_W-1:0]  rsp_id_q;
    logic [WIDTH:0]    rsp_data_q;
    logic [CNT_W-1:0]  op_count_q;
    logic              busy_q;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               any_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [1:0]         sel_op_s;
    logic [NUM_REQ-1:0] req_ready_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s),
        .any_o       (any_s)
    );

    // One-hot AND-OR mux of the winning requester's operand slices.
    always_comb begin
        sel_a_s  = '0;
        sel_b_s  = '0;
        sel_op_s = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s  = sel_a_s  | ({WIDTH{grant_s[i]}} & req_a[i*WIDTH +: WIDTH]);
            sel_b_s  = sel_b_s  | ({WIDTH{grant_s[i]}} & req_b[i*WIDTH +: WIDTH]);
            sel_op_s = sel_op_s | ({2{grant_s[i]}} & req_op[i*2 +: 2]);
        end
    end

    // Pointer moves one past the winner, wrapping at NUM_REQ.
    always_comb begin
        if (grant_idx_s == IDX_W'(NUM_REQ-1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx_s + IDX_W'(1);
        end
    end

    // Accept strobe exists only in IDLE and is forced low while reset is held.
    always_comb begin
        if ((state_q == S_IDLE) && !rst) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // Scheduler FSM; all ALU and response outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            alu_enable_q <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 2'b00;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            op_count_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_s) begin
                        alu_a_q      <= sel_a_s;
                        alu_b_q      <= sel_b_s;
                        alu_op_q     <= sel_op_s;
                        alu_enable_q <= 1'b1;
                        id_q         <= grant_idx_s;
                        ptr_q        <= ptr_d;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    rsp_data_q   <= {alu_cout, alu_out};
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    alu_enable_q <= 1'b0;
                    alu_a_q      <= '0;
                    alu_b_q      <= '0;
                    alu_op_q     <= 2'b00;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    alu_enable_q <= 1'b0;
                    rsp_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign alu_enable = alu_enable_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign op_count   = op_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural 4-bit ALU attached.
module tb_alu_rr_scheduler;

    localparam int NR = 4;
    localparam int W  = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [NR*2-1:0] req_op;
    logic [NR-1:0]   req_ready;
    logic            alu_enable;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [1:0]      alu_opcode;
    logic [W-1:0]    alu_out;
    logic            alu_cout;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W:0]      rsp_data;
    logic [CW-1:0]   op_count;
    logic            busy;
    logic [W:0]      alu_res;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_cnt;
    logic [3:0] oh;

    alu_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_op(req_op), .req_ready(req_ready),
        .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .op_count(op_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_res = 5'd0;
        if (alu_enable) begin
            case (alu_opcode)
                2'b00:   alu_res = {1'b0, alu_a} + {1'b0, alu_b};
                2'b01:   alu_res = {1'b0, alu_a} - {1'b0, alu_b};
                2'b10:   alu_res = {1'b0, alu_a & alu_b};
                default: alu_res = {1'b0, alu_a};
            endcase
        end
    end
    assign alu_out  = alu_res[3:0];
    assign alu_cout = alu_res[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-requester operation from IDLE through the response handshake.
    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [4:0] exp);
        logic [3:0] g;
        g = 4'b0001 << id;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*2 +: 2] = op;
        #1;
        chk("grant", 32'(req_ready), 32'(g));
        step();
        req_valid = '0;
        req_a[id*W +: W] = ~a;
        chk("issue_en", 32'(alu_enable), 32'd1);
        chk("issue_a", 32'(alu_a), 32'(a));
        chk("issue_b", 32'(alu_b), 32'(b));
        chk("issue_op", 32'(alu_opcode), 32'(op));
        chk("issue_rdy", 32'(req_ready), 32'd0);
        step();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(id), 32'(rsp_id) ^ 32'd0);
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        chk("rsp_alu_off", 32'(alu_enable), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("done_cnt", 32'(op_count), 32'(exp_cnt));
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b0;
        exp_cnt = 2'd0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_en", 32'(alu_enable), 32'd0);
        chk("rst_a", 32'(alu_a), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_cnt", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single request, add with carry out: 9+8 = 17.
        do_op(2, 4'd9, 4'd8, 2'b00, 5'b10001);

        // rsp_ready outside RESP is ignored.
        rsp_ready = 1'b1;
        step();
        chk("idle_rspready_cnt", 32'(op_count), 32'd1);
        chk("idle_rspready_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // Round robin from pointer 0 with all four requesters valid; count wraps.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 2'd0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = 4'(i + 1);
            req_b[i*W +: W] = 4'd2;
            req_op[i*2 +: 2] = 2'b00;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % NR);
            chk("rr_grant", 32'(req_ready), 32'(oh));
            step();
            chk("rr_issue_en", 32'(alu_enable), 32'd1);
            chk("rr_issue_a", 32'(alu_a), 32'((k % NR) + 1));
            chk("rr_issue_rdy", 32'(req_ready), 32'd0);
            step();
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % NR));
            chk("rr_rsp_data", 32'(rsp_data), 32'((k % NR) + 3));
            step();
            exp_cnt = exp_cnt + 2'd1;
            chk("rr_cnt", 32'(op_count), 32'(exp_cnt));
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        step();

        // Subtract, pass and AND results.
        do_op(0, 4'd3, 4'd5, 2'b01, 5'b11110);
        do_op(1, 4'hA, 4'h3, 2'b11, 5'b01010);
        do_op(2, 4'hC, 4'hA, 2'b10, 5'b01000);

        // Backpressure: five stalled cycles in RESP, then release.
        req_valid = 4'b1000;
        req_a[3*W +: W] = 4'd7;
        req_b[3*W +: W] = 4'd6;
        req_op[3*2 +: 2] = 2'b00;
        step();
        req_valid = 4'b0001;
        req_a[0 +: W] = 4'd1;
        req_b[0 +: W] = 4'd1;
        req_op[0 +: 2] = 2'b00;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'(5'b01101));
            chk("bp_id", 32'(rsp_id), 32'd3);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 2'd1;
        chk("bp_release_cnt", 32'(op_count), 32'(exp_cnt));
        chk("bp_next_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        chk("bp_next_a", 32'(alu_a), 32'd1);
        step();
        chk("bp_next_id", 32'(rsp_id), 32'd0);
        chk("bp_next_data", 32'(rsp_data), 32'(5'b00010));
        step();
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        chk("bp_next_cnt", 32'(op_count), 32'(exp_cnt));

        // Reset during ISSUE, then the pointer must be back at 0.
        req_valid = 4'b0100;
        req_a[2*W +: W] = 4'd5;
        req_b[2*W +: W] = 4'd5;
        step();
        req_valid = '0;
        chk("mid_issue_en", 32'(alu_enable), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_en", 32'(alu_enable), 32'd0);
        chk("mid_rst_a", 32'(alu_a), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rspv", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cnt", 32'(op_count), 32'd0);
        step();
        step();
        rst = 1'b0;
        exp_cnt = 2'd0;
        req_valid = 4'b1010;
        req_a[1*W +: W] = 4'd2;
        req_b[1*W +: W] = 4'd3;
        req_op[1*2 +: 2] = 2'b00;
        req_a[3*W +: W] = 4'd6;
        req_b[3*W +: W] = 4'd1;
        req_op[3*2 +: 2] = 2'b01;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid = 4'b1000;
        chk("post_rst_a", 32'(alu_a), 32'd2);
        step();
        chk("post_rst_id", 32'(rsp_id), 32'd1);
        chk("post_rst_data", 32'(rsp_data), 32'(5'b00101));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        chk("post_rst_cnt", 32'(op_count), 32'(exp_cnt));
        chk("post_rst_grant3", 32'(req_ready), 32'(4'b1000));
        do_op(3, 4'd6, 4'd1, 2'b01, 5'b00101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
